// File: rtl/led_bank_arbiter_pkg.sv
// Shared constants and types for the LED bank arbiter.
// Other files use them through import led_arb_pkg::*.
package led_arb_pkg;

    localparam int          LED_W_DEFAULT        = 16;
    localparam logic [15:0] IDLE_PATTERN_DEFAULT = 16'hAE20;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } arb_state_t;

endpackage

// File: rtl/led_bank_arbiter_if.sv
// Request/pattern bus between the pattern sources and the LED bank arbiter.
// The grant, busy and flag_led signals travel back on the same bus.
interface led_bank_arbiter_if
    import led_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int LED_W   = LED_W_DEFAULT
);
    logic [NUM_REQ-1:0]       req;
    logic [NUM_REQ*LED_W-1:0] pattern;
    logic [NUM_REQ-1:0]       grant;
    logic                     busy;
    logic [LED_W-1:0]         flag_led;

    modport master (output req, pattern, input grant, busy, flag_led);
    modport slave  (input req, pattern, output grant, busy, flag_led);
endinterface

// File: rtl/led_rr_pick.sv
// Combinational round-robin picker. It chooses the first requester that is
// both requesting and unmasked, searching upward from start and wrapping.
module led_rr_pick
    import led_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] mask,
    input  logic [IDX_W-1:0]   start,
    output logic               valid,
    output logic [IDX_W-1:0]   winner
);

    logic [NUM_REQ-1:0] cand;
    logic [IDX_W:0]     sum [NUM_REQ];
    logic [IDX_W-1:0]   pos [NUM_REQ];

    assign cand = req & mask;

    // pos[gi] is the requester index at search offset gi from start
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_pos
            assign sum[gi] = {1'b0, start} + (IDX_W+1)'(gi);
            assign pos[gi] = (sum[gi] >= (IDX_W+1)'(NUM_REQ))
                           ? IDX_W'(sum[gi] - (IDX_W+1)'(NUM_REQ))
                           : sum[gi][IDX_W-1:0];
        end
    endgenerate

    // Scan from the far end so that the nearest candidate is written last.
    always_comb begin
        valid  = 1'b0;
        winner = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (cand[pos[k]]) begin
                valid  = 1'b1;
                winner = pos[k];
            end
        end
    end

endmodule

// File: rtl/led_bank_arbiter.sv
// Round-robin owner of the shared LED bank. Each grant has a fixed dwell time,
// and the bank shows the idle pattern whenever no source requests it.
module led_bank_arbiter
    import led_arb_pkg::*;
#(
    parameter int               NUM_REQ      = 4,
    parameter int               LED_W        = LED_W_DEFAULT,
    parameter int               DWELL_CYCLES = 100_000_000,
    parameter logic [LED_W-1:0] IDLE_PATTERN = LED_W'(IDLE_PATTERN_DEFAULT)
) (
    input  logic               clk,
    input  logic               rst_n,
    led_bank_arbiter_if.slave  bus
);

    localparam int               IDX_W    = $clog2(NUM_REQ);
    localparam int               CNT_W    = $clog2(DWELL_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DWELL_CYCLES - 1);

    arb_state_t         state_reg, state_next;
    logic [NUM_REQ-1:0] grant_reg, grant_next;
    logic               busy_reg, busy_next;
    logic [LED_W-1:0]   led_reg, led_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic [IDX_W-1:0]   ptr_reg, ptr_next;
    logic [IDX_W-1:0]   owner_reg, owner_next;

    logic [LED_W-1:0]   pat [NUM_REQ];
    logic [NUM_REQ-1:0] pick_mask;
    logic               pick_valid;
    logic [IDX_W-1:0]   pick_idx;
    logic               owner_req;
    logic               rearb;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_pat
            assign pat[gi] = bus.pattern[gi*LED_W +: LED_W];
        end
    endgenerate

    // In HOLD the pointer equals owner+1, so one start index covers both states.
    // When the owner releases early, it is masked out of that pick.
    assign owner_req = bus.req[owner_reg];
    assign pick_mask = (state_reg == HOLD && !owner_req)
                     ? ~(NUM_REQ'(1) << owner_reg) : '1;

    led_rr_pick #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_pick (
        .req    (bus.req),
        .mask   (pick_mask),
        .start  (ptr_reg),
        .valid  (pick_valid),
        .winner (pick_idx)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            grant_reg <= '0;
            busy_reg  <= 1'b0;
            led_reg   <= IDLE_PATTERN;
            cnt_reg   <= '0;
            ptr_reg   <= '0;
            owner_reg <= '0;
        end else begin
            state_reg <= state_next;
            grant_reg <= grant_next;
            busy_reg  <= busy_next;
            led_reg   <= led_next;
            cnt_reg   <= cnt_next;
            ptr_reg   <= ptr_next;
            owner_reg <= owner_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        grant_next = grant_reg;
        busy_next  = busy_reg;
        led_next   = led_reg;
        cnt_next   = cnt_reg;
        ptr_next   = ptr_reg;
        owner_next = owner_reg;
        rearb      = (state_reg == IDLE) || (cnt_reg == '0) || !owner_req;

        if (!rearb) begin
            led_next = pat[owner_reg];
            cnt_next = cnt_reg - CNT_W'(1);
        end else if (pick_valid) begin
            state_next = HOLD;
            grant_next = NUM_REQ'(1) << pick_idx;
            busy_next  = 1'b1;
            led_next   = pat[pick_idx];
            cnt_next   = CNT_LOAD;
            owner_next = pick_idx;
            ptr_next   = (pick_idx == IDX_W'(NUM_REQ - 1)) ? '0 : pick_idx + IDX_W'(1);
        end else begin
            state_next = IDLE;
            grant_next = '0;
            busy_next  = 1'b0;
            led_next   = IDLE_PATTERN;
        end
    end

    assign bus.grant    = grant_reg;
    assign bus.busy     = busy_reg;
    assign bus.flag_led = led_reg;

endmodule
